// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. A single sum/carry cell plus a carry flip-flop
//   process one operand bit per clock, LSB first. An accepted start latches the
//   operands. WIDTH SHIFT cycles then follow. On the last one, sum and carry are
//   registered and done pulses for one cycle in the following DONE state.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     When defined, a `sub` input is added. With sub=1, x - y is computed in
//     two's complement by inverting y and seeding the carry with 1. carry=1
//     then means "no borrow" (x >= y unsigned).
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, honoured only in IDLE or DONE
//   x      in   WIDTH  operand A, captured on accepted start
//   y      in   WIDTH  operand B, captured on accepted start
//   sub    in   1      subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   out  1      high while shifting
//   done   out  1      one-cycle pulse when sum/carry become valid
//   sum    out  WIDTH  registered result
//   carry  out  1      carry-out of the MSB
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_xr;
  logic [WIDTH-1:0] r_yr;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_cf;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_sub;
  logic             w_bit;
  logic             w_cf_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // The single sum/carry cell operating on the current LSBs.
  assign w_bit      = r_xr[0] ^ r_yr[0] ^ r_cf;
  assign w_cf_next  = (r_xr[0] & r_yr[0]) | (r_cf & (r_xr[0] ^ r_yr[0]));
  // Result bits enter at the MSB end so that after WIDTH shifts the first
  // (LSB) result bit has arrived in bit 0.
  assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_xr    <= '0;
      r_yr    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_cf    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction is x + ~y + 1; the +1 rides in on the carry seed.
            r_xr    <= x;
            r_yr    <= w_sub ? ~y : y;
            r_cf    <= w_sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_cf  <= w_cf_next;
          r_res <= w_res_next;
          r_xr  <= r_xr >> 1;
          r_yr  <= r_yr >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_res_next;
            r_carry <= w_cf_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder (WIDTH=8). Inputs change 1 ns after each
//   rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int vectors = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues start in the current cycle (T), then checks busy in T+1..T+W with
  // the old result held, and the done pulse with the new result in T+W+1.
  // If ign_at is nonzero, a stray start with x=0x77 is pulsed in cycle T+ign_at.
  // Returns in the done cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] prev_sum, input logic prev_c,
                        input logic [W-1:0] exp_sum, input logic exp_c, input int ign_at);
    x = a;
    y = b;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`else
    if (s) $display("note: %s subtract request ignored in add-only build", tag);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    x = 8'h00;
    y = 8'h00;
    for (int k = 1; k <= W; k++) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      check({tag, " done_low"}, {31'd0, done}, 32'd0);
      check({tag, " sum_held"}, {24'd0, sum}, {24'd0, prev_sum});
      check({tag, " carry_held"}, {31'd0, carry}, {31'd0, prev_c});
      if (k == ign_at) begin
        x = 8'h77;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      x = 8'h00;
    end
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy_low"}, {31'd0, busy}, 32'd0);
    check({tag, " sum"}, {24'd0, sum}, {24'd0, exp_sum});
    check({tag, " carry"}, {31'd0, carry}, {31'd0, exp_c});
    $display("op %s: x=0x%02h y=0x%02h sub=%0d -> sum=0x%02h carry=%0d", tag, a, b, s, sum, carry);
  endtask

  initial begin
    // 1. Reset held two cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst sum", {24'd0, sum}, 32'h00);
    check("rst carry", {31'd0, carry}, 32'd0);
    tick();
    check("idle busy", {31'd0, busy}, 32'd0);

    // 2. Basic add.
    run_op("add5A33", 8'h5A, 8'h33, 1'b0, 8'h00, 1'b0, 8'h8D, 1'b0, 0);
    tick();
    check("add5A33 done_once", {31'd0, done}, 32'd0);
    check("add5A33 idle", {31'd0, busy}, 32'd0);
    check("add5A33 sum_hold", {24'd0, sum}, 32'h8D);

    // 3. Carry out, then a back-to-back start issued in the DONE cycle.
    run_op("addFF01", 8'hFF, 8'h01, 1'b0, 8'h8D, 1'b0, 8'h00, 1'b1, 0);
    run_op("addFFFF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b1, 0);
    tick();
    check("addFFFF done_once", {31'd0, done}, 32'd0);

    // Alternating bits: no carry should propagate anywhere.
    run_op("addAA55", 8'hAA, 8'h55, 1'b0, 8'hFE, 1'b1, 8'hFF, 1'b0, 0);
    tick();

    // 4. Start during SHIFT (at T+3) must be ignored.
    run_op("add0101", 8'h01, 8'h01, 1'b0, 8'hFF, 1'b0, 8'h02, 1'b0, 3);
    tick();
    check("ignored busy", {31'd0, busy}, 32'd0);
    check("ignored done", {31'd0, done}, 32'd0);

    // 5. Reset in the middle of an operation.
    x = 8'h80;
    y = 8'h80;
    start = 1'b1;
    tick();              // now in T+1
    start = 1'b0;
    tick();
    tick();
    tick();              // now in T+4
    check("mid busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort sum", {24'd0, sum}, 32'h00);
    check("abort carry", {31'd0, carry}, 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      tick();
      check("abort no_done", {31'd0, done}, 32'd0);
    end
    $display("abort: x=0x80 y=0x80 reset at T+4 -> busy=%0d sum=0x%02h", busy, sum);

`ifdef SERIAL_ADDER_SUB_EN
    // 6. Subtraction.
    run_op("sub1001", 8'h10, 8'h01, 1'b1, 8'h00, 1'b0, 8'h0F, 1'b1, 0);
    run_op("sub0102", 8'h01, 8'h02, 1'b1, 8'h0F, 1'b1, 8'hFF, 1'b0, 0);
    run_op("add_after_sub", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 8'h03, 1'b0, 0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Backstop so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
